// File: rtl/bch_gf16_pkg.sv
// GF(16) arithmetic and shared types for the BCH(15,7,t=2) receive path.
// Field polynomial p(x) = x^4 + x + 1, elements held in polynomial basis.
package bch_gf16_pkg;

  localparam int         CW_LEN  = 15;
  localparam int         GF16_M  = 4;
  localparam logic [4:0] GF_PRIM = 5'b10011;

  typedef logic [GF16_M-1:0] gf16_t;

  typedef enum logic {
    FRM_IDLE,
    FRM_SHIFT
  } frame_state_e;

  typedef struct packed {
    logic [CW_LEN-1:0] cw;
    gf16_t             s1;
    gf16_t             s3;
    logic              resync;
  } rx_word_t;

  // alpha^i for i = 0..14, shared with the locator and Chien stages
  localparam gf16_t GF16_ALPHA_POW [CW_LEN] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  function automatic gf16_t gf16_alpha_pow(input int unsigned i);
    return GF16_ALPHA_POW[i % CW_LEN];
  endfunction

  function automatic gf16_t gf16_mul_alpha(input gf16_t a);
    return {a[2:0], 1'b0} ^ (a[3] ? GF_PRIM[3:0] : 4'h0);
  endfunction

  function automatic gf16_t gf16_mul_alpha3(input gf16_t a);
    return gf16_mul_alpha(gf16_mul_alpha(gf16_mul_alpha(a)));
  endfunction

endpackage

// File: rtl/bch_serial_syndrome_rx_if.sv
// Bit-serial input stream and word/syndrome output handshake of the BCH receive front-end.
interface bch_serial_syndrome_rx_if;
  import bch_gf16_pkg::*;

  logic              in_bit;
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;
  logic [CW_LEN-1:0] out_cw;
  gf16_t             out_s1;
  gf16_t             out_s3;
  logic              out_err;
  logic              out_resync;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_bit, in_valid, in_sof, out_ready,
    input  in_ready, out_cw, out_s1, out_s3, out_err, out_resync, out_valid
  );

  modport slave (
    input  in_bit, in_valid, in_sof, out_ready,
    output in_ready, out_cw, out_s1, out_s3, out_err, out_resync, out_valid
  );

endinterface

// File: rtl/bch_syndrome_lfsr.sv
// One Horner syndrome accumulator: acc <- acc * alpha^POWER + bit, MSB first.
module bch_syndrome_lfsr
  import bch_gf16_pkg::*;
#(
  parameter int POWER = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  step_i,
  input  logic  bit_i,
  output gf16_t syn_next_o
);

  gf16_t acc_q, acc_d, accMul;

  if (POWER == 3) begin : gPow3
    assign accMul = gf16_mul_alpha3(acc_q);
  end else begin : gPow1
    assign accMul = gf16_mul_alpha(acc_q);
  end

  // A load restarts the polynomial so nothing carries over from a previous frame
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = {3'b000, bit_i};
    end else if (step_i) begin
      acc_d = accMul ^ {3'b000, bit_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign syn_next_o = acc_d;

endmodule

// File: rtl/bch_serial_syndrome_rx.sv
// BCH(15,7) serial receive front-end: frames 15 bits MSB-first, computes S1/S3 on the fly
// and hands each word downstream through a one-deep valid/ready output register.
module bch_serial_syndrome_rx #(
  parameter int CW_LEN = 15,
  parameter int GF_M   = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  bch_serial_syndrome_rx_if.slave bus
);
  import bch_gf16_pkg::*;

  localparam int               CNT_W    = $clog2(CW_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_LEN - 1);

  frame_state_e      state_q, state_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [CW_LEN-1:0] sr_q, sr_d;
  logic              resync_q, resync_d;
  rx_word_t          outWord_q, outWord_d;
  logic              outValid_q, outValid_d;

  logic              inReady;
  logic              accept;
  logic              frameStart;
  logic              frameDone;
  logic [GF_M-1:0]   s1Next;
  logic [GF_M-1:0]   s3Next;

  // Only the completing bit can stall: it needs the output register to be free
  assign inReady    = !(bitCnt_q == LAST_CNT && outValid_q && !bus.out_ready);
  assign accept     = bus.in_valid && inReady;
  assign frameStart = accept && (state_q == FRM_IDLE || bus.in_sof);
  assign frameDone  = accept && !frameStart && (bitCnt_q == LAST_CNT);

  bch_syndrome_lfsr #(.POWER(1)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (frameStart),
    .step_i     (accept && !frameStart),
    .bit_i      (bus.in_bit),
    .syn_next_o (s1Next)
  );

  bch_syndrome_lfsr #(.POWER(3)) u_s3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (frameStart),
    .step_i     (accept && !frameStart),
    .bit_i      (bus.in_bit),
    .syn_next_o (s3Next)
  );

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    sr_d       = sr_q;
    resync_d   = resync_q;
    outWord_d  = outWord_q;
    outValid_d = outValid_q;

    if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end

    if (frameStart) begin
      state_d  = FRM_SHIFT;
      bitCnt_d = CNT_W'(1);
      sr_d     = CW_LEN'(bus.in_bit);
      if (state_q == FRM_SHIFT) begin
        resync_d = 1'b1;
      end
    end else if (accept) begin
      sr_d = {sr_q[CW_LEN-2:0], bus.in_bit};
      if (frameDone) begin
        // A completion overrides a same-cycle consume, so out_valid stays high
        state_d    = FRM_IDLE;
        bitCnt_d   = '0;
        resync_d   = 1'b0;
        outValid_d = 1'b1;
        outWord_d  = '{cw: sr_d, s1: s1Next, s3: s3Next, resync: resync_q};
      end else begin
        bitCnt_d = bitCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FRM_IDLE;
      bitCnt_q   <= '0;
      sr_q       <= '0;
      resync_q   <= 1'b0;
      outWord_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      sr_q       <= sr_d;
      resync_q   <= resync_d;
      outWord_q  <= outWord_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.out_cw     = outWord_q.cw;
  assign bus.out_s1     = outWord_q.s1;
  assign bus.out_s3     = outWord_q.s3;
  assign bus.out_err    = (|outWord_q.s1) || (|outWord_q.s3);
  assign bus.out_resync = outWord_q.resync;
  assign bus.out_valid  = outValid_q;

endmodule

// File: tb/tb_bch_serial_syndrome_rx.sv
// Self-checking bench for bch_serial_syndrome_rx: directed cases plus randomized frames
// checked against a power-sum syndrome model and a queue of expected output words.
module tb_bch_serial_syndrome_rx;

  typedef struct {
    logic [14:0] cw;
    logic [3:0]  s1;
    logic [3:0]  s3;
    logic        resync;
  } expWord_t;

  logic clk = 1'b0;
  logic rst_n;

  bch_serial_syndrome_rx_if bus ();

  bch_serial_syndrome_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          alphaPow [15];
  expWord_t    expQ [$];
  int          modelCnt;
  logic [14:0] modelCw;
  logic        modelResync;
  int          readyMode;
  bit          gapsOn;
  bit          monitorOn;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Syndrome as the sum of alpha^(k*i) over the set bits of the word
  function automatic logic [3:0] synPow(input logic [14:0] cw, input int k);
    int s;
    s = 0;
    for (int i = 0; i < 15; i++) begin
      if (cw[i]) s = s ^ alphaPow[(i * k) % 15];
    end
    return 4'(s);
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
    case (readyMode)
      0:       bus.out_ready = 1'($urandom_range(0, 1));
      1:       bus.out_ready = 1'b0;
      2:       bus.out_ready = 1'b1;
      default: begin
        bus.out_ready = 1'b1;
        readyMode     = 1;
      end
    endcase
  endtask

  task automatic modelAccept(input logic b, input logic sof);
    expWord_t w;
    if (modelCnt == 0 || sof) begin
      if (modelCnt != 0) modelResync = 1'b1;
      modelCw  = {14'b0, b};
      modelCnt = 1;
    end else begin
      modelCw  = {modelCw[13:0], b};
      modelCnt = modelCnt + 1;
      if (modelCnt == 15) begin
        w.cw        = modelCw;
        w.s1        = synPow(modelCw, 1);
        w.s3        = synPow(modelCw, 3);
        w.resync    = modelResync;
        expQ.push_back(w);
        modelResync = 1'b0;
        modelCnt    = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic b, input logic sof);
    bit accepted;
    int waitCycles;
    if (gapsOn && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'($urandom);
        bus.in_sof   = 1'($urandom);
        stepCycle();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_sof   = sof;
    accepted     = 1'b0;
    waitCycles   = 0;
    while (!accepted && waitCycles < 200) begin
      @(negedge clk);
      accepted = bus.in_ready;
      stepCycle();
      waitCycles++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    if (accepted) modelAccept(b, sof);
    else checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendFrame(input logic [14:0] cw, input int nBits, input logic sof);
    for (int i = 0; i < nBits; i++) begin
      applyStimulus(cw[14-i], (i == 0) ? sof : 1'b0);
    end
  endtask

  task automatic consumeWord();
    readyMode = 3;
    stepCycle();
    stepCycle();
  endtask

  task automatic checkWord(input string tag, input logic [14:0] cw, input logic [3:0] s1,
                           input logic [3:0] s3, input logic err, input logic resync);
    @(negedge clk);
    checkOutput({tag, "_valid"},  bus.out_valid,  1);
    checkOutput({tag, "_cw"},     bus.out_cw,     cw);
    checkOutput({tag, "_s1"},     bus.out_s1,     s1);
    checkOutput({tag, "_s3"},     bus.out_s3,     s3);
    checkOutput({tag, "_err"},    bus.out_err,    err);
    checkOutput({tag, "_resync"}, bus.out_resync, resync);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"},    bus.out_valid,  0);
    checkOutput({tag, "_cw"},       bus.out_cw,     0);
    checkOutput({tag, "_s1"},       bus.out_s1,     0);
    checkOutput({tag, "_s3"},       bus.out_s3,     0);
    checkOutput({tag, "_err"},      bus.out_err,    0);
    checkOutput({tag, "_resync"},   bus.out_resync, 0);
    checkOutput({tag, "_in_ready"}, bus.in_ready,   1);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    expQ.delete();
    modelCnt    = 0;
    modelResync = 1'b0;
    #1;
    checkResetState("midrst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    stepCycle();
  endtask

  // Scoreboard: whenever a word is owed downstream it must be presented, unchanged, until taken
  always @(negedge clk) begin
    if (monitorOn && rst_n) begin
      logic expReady;
      expReady = !(modelCnt == 14 && expQ.size() != 0 && !bus.out_ready);
      checkOutput("in_ready",  bus.in_ready,  expReady);
      checkOutput("out_valid", bus.out_valid, expQ.size() != 0);
      if (expQ.size() != 0) begin
        checkOutput("out_cw",     bus.out_cw,     expQ[0].cw);
        checkOutput("out_s1",     bus.out_s1,     expQ[0].s1);
        checkOutput("out_s3",     bus.out_s3,     expQ[0].s3);
        checkOutput("out_err",    bus.out_err,    (expQ[0].s1 != 0) || (expQ[0].s3 != 0));
        checkOutput("out_resync", bus.out_resync, expQ[0].resync);
        if (bus.out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    testsFailed++;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    int a;
    a = 1;
    for (int i = 0; i < 15; i++) begin
      alphaPow[i] = a;
      a = a << 1;
      if ((a & 16) != 0) a = a ^ 19;
    end

    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_sof   = 1'b0;
    bus.out_ready = 1'b0;
    readyMode    = 1;
    gapsOn       = 1'b0;
    monitorOn    = 1'b0;
    modelCnt     = 0;
    modelCw      = '0;
    modelResync  = 1'b0;

    #2 rst_n = 1'b0;
    #1 checkResetState("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    stepCycle();
    monitorOn = 1'b1;

    $display("[TB] valid codeword");
    sendFrame(15'h01D1, 15, 1'b1);
    checkWord("cw_ok", 15'h01D1, 4'd0, 4'd0, 1'b0, 1'b0);
    consumeWord();

    $display("[TB] single and double errors");
    sendFrame(15'h0001, 15, 1'b1);
    checkWord("err_x0", 15'h0001, 4'd1, 4'd1, 1'b1, 1'b0);
    consumeWord();
    sendFrame(15'h4000, 15, 1'b1);
    checkWord("err_x14", 15'h4000, 4'd9, 4'd15, 1'b1, 1'b0);
    consumeWord();
    sendFrame(15'h0003, 15, 1'b1);
    checkWord("err_dbl", 15'h0003, 4'd3, 4'd9, 1'b1, 1'b0);
    consumeWord();

    $display("[TB] output hold and completing-bit stall");
    sendFrame(15'h0001, 15, 1'b1);
    sendFrame(15'h4000, 14, 1'b1);
    stepCycle();
    stepCycle();
    @(negedge clk);
    checkOutput("hold_in_ready", bus.in_ready, 0);
    checkOutput("hold_cw",       bus.out_cw,   15'h0001);
    stepCycle();
    readyMode = 3;
    applyStimulus(1'b0, 1'b0);
    checkWord("hold_next", 15'h4000, 4'd9, 4'd15, 1'b1, 1'b0);
    consumeWord();

    $display("[TB] resync on mid-frame sof");
    sendFrame(15'h2AB5, 6, 1'b1);
    sendFrame(15'h01D1, 15, 1'b1);
    checkWord("resync", 15'h01D1, 4'd0, 4'd0, 1'b0, 1'b1);
    consumeWord();
    sendFrame(15'h01D1, 15, 1'b1);
    checkWord("post_resync", 15'h01D1, 4'd0, 4'd0, 1'b0, 1'b0);
    consumeWord();

    $display("[TB] reset mid-frame with output pending");
    sendFrame(15'h0003, 15, 1'b1);
    sendFrame(15'h1234, 8, 1'b1);
    pulseReset();
    @(negedge clk);
    checkOutput("no_stale_valid", bus.out_valid, 0);
    stepCycle();
    sendFrame(15'h0001, 15, 1'b1);
    checkWord("after_rst", 15'h0001, 4'd1, 4'd1, 1'b1, 1'b0);
    consumeWord();

    $display("[TB] randomized frames");
    readyMode = 0;
    gapsOn    = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [14:0] cw;
      logic [6:0]  msg;
      if ($urandom_range(0, 4) == 0) begin
        sendFrame(15'($urandom), $urandom_range(1, 14), 1'($urandom));
      end
      msg = 7'($urandom);
      cw  = '0;
      for (int i = 0; i < 7; i++) begin
        if (msg[i]) cw = cw ^ (15'h01D1 << i);
      end
      case ($urandom_range(0, 2))
        1:       cw = cw ^ (15'd1 << $urandom_range(0, 14));
        2:       cw = 15'($urandom);
        default: ;
      endcase
      sendFrame(cw, 15, 1'($urandom_range(0, 1)));
    end

    readyMode = 2;
    gapsOn    = 1'b0;
    repeat (4) stepCycle();
    @(negedge clk);
    checkOutput("drain_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bch_serial_syndrome_rx.md
Name: bch_serial_syndrome_rx

Overview:
Bit-serial receive front-end for the BCH(15,7,t=2) decoder path. It accepts received codeword bits one per cycle, MSB (x^14) first, and frames them into 15-bit words. While the bits shift in, it computes syndromes S1 = r(alpha) and S3 = r(alpha^3) over GF(16) (p(x) = x^4+x+1) using Horner recurrences. It presents each completed word plus its syndromes to the downstream error-locator / Chien stage through a valid/ready handshake with one-deep output buffering.

Parameters:
CW_LEN, 15, codeword length in bits; only 15 is supported and elaborates the frame counter.
GF_M, 4, field width in bits for S1/S3; only 4 is supported.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_bit  in  1  received codeword bit.
in_valid  in  1  in_bit is valid this cycle.
in_sof  in  1  qualified by in_valid: in_bit is x^14, the first bit of a new frame.
in_ready  out  1  block accepts in_bit this cycle.
out_cw  out  15  completed received word, bit i = coefficient of x^i.
out_s1  out  4  syndrome S1, polynomial-basis value.
out_s3  out  4  syndrome S3.
out_err  out  1  (out_s1 != 0) || (out_s3 != 0).
out_resync  out  1  this frame was started by in_sof while a previous frame was partial.
out_valid  out  1  output word is valid.
out_ready  in  1  downstream consumes the word.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: every output is 0, except in_ready = 1. Internal state is also cleared: shift register, bit counter (0..14), S1/S3 accumulators, resync flag.
- Accept condition: an input transfer happens when in_valid && in_ready.
- Syndrome recurrences, applied on every accept:
  - s1 <= mulA(s1) ^ {3'b0, in_bit}
  - s3 <= mulA3(s3) ^ {3'b0, in_bit}
  - mulA is multiply by alpha. With a = {a3,a2,a1,a0}: mulA = {a2, a1, a0^a3, a3}.
  - mulA3 is mulA applied three times, implemented as pure combinational XOR.
  - Shift register: sr <= {sr[13:0], in_bit}.
- Framing states:
  - IDLE: bit_cnt = 0, no partial frame.
  - SHIFT: 1 <= bit_cnt <= 14.
  - The accept that takes bit_cnt from 14 to 0 completes the frame.
- Frame start: the first bit of a frame is the accept made in IDLE, or any accept with in_sof = 1.
  - That accept loads s1 = s3 = {3'b0, in_bit}, sr = {14'b0, in_bit}, bit_cnt = 1.
  - Accumulators never carry across frames.
- in_sof with bit_cnt != 0:
  - The partial frame is discarded and the new frame starts as above.
  - The resync flag is set; it is reported with the next completed frame, then cleared.
- in_sof with bit_cnt == 0: normal frame start, no resync.
- Completion:
  - On the cycle after the 15th accept, the output register holds {sr, s1, s3, resync}.
  - out_valid = 1 on that cycle, so latency from the last bit to out_valid is 1 cycle.
  - Back-to-back frames run with no bubble.
- Output hold: while out_valid && !out_ready, all out_* signals stay stable.
- in_ready = !(bit_cnt == 14 && out_valid && !out_ready).
  - Only the completing bit stalls.
  - Bits 1..14 of the next frame are accepted while the output is held.
- Simultaneous events: if the output is consumed (out_ready = 1) on the same cycle a frame completes, the new word loads and out_valid stays 1.
- out_valid falls only on out_ready with no new completion that cycle.
- in_valid = 0 mid-frame: the frame simply pauses; there is no timeout.
- Reset mid-frame or with output pending: everything is discarded, and no out_valid is generated for the partial frame.

Decomposition:
- Package bch_gf16_pkg holds:
  - GF_PRIM = 5'b10011 and CW_LEN = 15.
  - Functions gf16_mul_alpha and gf16_mul_alpha3.
  - The alpha power table already used by the decoder stages.
- Sub-module bch_syndrome_lfsr: one Horner accumulator, parameterised by the multiply-by-alpha^k power (1 or 3), with load/step enables. It is instantiated twice.
- Framing FSM, shift register and output buffer stay in the top.

Test Plan:
1. Valid codeword 0x01D1 (message 0x01), bits sent 14..0 with sof on bit 14 → one cycle after the last bit: out_cw = 0x01D1, s1 = 0, s3 = 0, out_err = 0, out_valid = 1.
2. Single-error words, each followed by one cycle of out_ready:
   - cw 0x0001 → s1 = 1, s3 = 1, err = 1.
   - cw 0x4000 → s1 = 9, s3 = 15, err = 1.
3. Double error, cw 0x0003 → s1 = 3, s3 = 9, out_err = 1.
4. Hold 0x0001 with out_ready = 0, stream the next frame 0x4000 → in_ready drops only when bit_cnt = 14; first word stays stable; after out_ready pulses, second word appears with s1 = 9, s3 = 15.
5. Send 6 bits, then in_sof with a full 0x01D1 frame → out_cw = 0x01D1, syndromes 0, out_resync = 1. A following clean frame has out_resync = 0.
6. Assert rst_n = 0 mid-frame (8 bits in) → outputs clear asynchronously and in_ready = 1. A fresh 0x0001 frame afterwards gives s1 = 1, s3 = 1, with no stale word emitted.
